// File: rtl/lfsr_msg_feeder.sv
// LFSR-to-DES message FIFO with pause backpressure, overflow flag and end-of-stream.
// Optional FEEDER_STATS_EN adds a 64-bit forwarded-word counter on msg_count.
module lfsr_msg_feeder #(
    parameter int DEPTH = 16,
    parameter int SLACK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [63:0] lfsr_data,
    input  logic        lfsr_valid,
    input  logic        lfsr_done,
    output logic        lfsr_pause,
    output logic [63:0] msg_data,
    output logic        msg_valid,
    input  logic        msg_ready,
    output logic        stream_done,
    output logic        overflow,
    output logic [63:0] msg_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_HIGH = CW'(DEPTH - SLACK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          pause_q, pause_d;
    state_e        state_q, state_d;

    logic push;
    logic pop;
    logic full;
    logic do_write;

    assign push = lfsr_valid;
    assign full = (count_q == CNT_FULL);
    assign msg_valid = (count_q != '0);
    assign pop = msg_valid & msg_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign do_write = push & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d = count_q;
        overflow_d = overflow_q | (push & full & ~pop);
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_write, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (lfsr_valid) begin
                    state_d = STREAM;
                end else if (lfsr_done) begin
                    state_d = DONE;
                end
            end
            STREAM: begin
                if (lfsr_done && !lfsr_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((count_q == '0) || ((count_q == CNT_ONE) && pop)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pause_d = 1'b0;
        if ((state_d == STREAM) || (state_d == DRAIN)) begin
            pause_d = (count_d >= CNT_HIGH);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            overflow_q <= 1'b0;
            pause_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            overflow_q <= overflow_d;
            pause_q <= pause_d;
            state_q <= state_d;
        end
    end

    // Storage is not reset; msg_data is gated so stale entries never show.
    always_ff @(posedge clk) begin
        if (rst_n && !clear && do_write) begin
            mem_q[wr_ptr_q] <= lfsr_data;
        end
    end

    assign msg_data = msg_valid ? mem_q[rd_ptr_q] : 64'h0;
    assign lfsr_pause = pause_q;
    assign overflow = overflow_q;
    assign stream_done = (state_q == DONE);

`ifdef FEEDER_STATS_EN
    logic [63:0] msg_count_q, msg_count_d;

    always_comb begin
        msg_count_d = msg_count_q;
        if (pop) begin
            msg_count_d = msg_count_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            msg_count_q <= 64'h0;
        end else begin
            msg_count_q <= msg_count_d;
        end
    end

    assign msg_count = msg_count_q;
`else
    assign msg_count = 64'h0;
`endif

endmodule

// File: tb/tb_lfsr_msg_feeder.sv
// Directed bench for lfsr_msg_feeder (DEPTH=16, SLACK=4).
// Expected values are hand-derived from the FIFO/FSM behaviour.
module tb_lfsr_msg_feeder;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [63:0] lfsr_data;
    logic        lfsr_valid;
    logic        lfsr_done;
    logic        lfsr_pause;
    logic [63:0] msg_data;
    logic        msg_valid;
    logic        msg_ready;
    logic        stream_done;
    logic        overflow;
    logic [63:0] msg_count;

    int total = 0;
    int fails = 0;

    lfsr_msg_feeder #(.DEPTH(16), .SLACK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .lfsr_data  (lfsr_data),
        .lfsr_valid (lfsr_valid),
        .lfsr_done  (lfsr_done),
        .lfsr_pause (lfsr_pause),
        .msg_data   (msg_data),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .stream_done(stream_done),
        .overflow   (overflow),
        .msg_count  (msg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int popped;
        logic [63:0] exp_cnt;
        rst_n = 1'b0;
        clear = 1'b0;
        lfsr_data = 64'h0;
        lfsr_valid = 1'b0;
        lfsr_done = 1'b0;
        msg_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(msg_valid), 64'd0);
        chk("rst_data", msg_data, 64'd0);
        chk("rst_pause", 64'(lfsr_pause), 64'd0);
        chk("rst_done", 64'(stream_done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_mcnt", msg_count, 64'd0);
        chk("rst_count", 64'(dut.count_q), 64'd0);
        rst_n = 1'b1;

        // 1: streaming pass-through, one-cycle latency
        msg_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            lfsr_data = 64'(i);
            lfsr_valid = 1'b1;
            tick();
            chk("t1_valid", 64'(msg_valid), 64'd1);
            chk("t1_data", msg_data, 64'(i));
        end
        lfsr_valid = 1'b0;
        tick();
        chk("t1_empty", 64'(msg_valid), 64'd0);
        chk("t1_ovf", 64'(overflow), 64'd0);

        // 2: pause after 12th stored word, 2 words in flight
        msg_ready = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            lfsr_data = 64'h200 + 64'(k);
            lfsr_valid = 1'b1;
            tick();
            chk("t2_pause", 64'(lfsr_pause), (k >= 12) ? 64'd1 : 64'd0);
        end
        for (int k = 13; k <= 14; k++) begin
            lfsr_data = 64'h200 + 64'(k);
            tick();
        end
        lfsr_valid = 1'b0;
        tick();
        chk("t2_count", 64'(dut.count_q), 64'd14);
        chk("t2_ovf", 64'(overflow), 64'd0);
        chk("t2_pause_hold", 64'(lfsr_pause), 64'd1);

        // 3: full FIFO overflow, then push+pop at full
        lfsr_valid = 1'b1;
        for (int k = 15; k <= 16; k++) begin
            lfsr_data = 64'h200 + 64'(k);
            tick();
        end
        chk("t3_full", 64'(dut.count_q), 64'd16);
        lfsr_data = 64'hDEAD;
        tick();
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_drop_cnt", 64'(dut.count_q), 64'd16);
        lfsr_data = 64'hBEEF;
        msg_ready = 1'b1;
        tick();
        lfsr_valid = 1'b0;
        chk("t3_pp_cnt", 64'(dut.count_q), 64'd16);
        chk("t3_ovf_sticky", 64'(overflow), 64'd1);
        for (int k = 2; k <= 16; k++) begin
            chk("t3_order", msg_data, 64'h200 + 64'(k));
            tick();
        end
        chk("t3_last", msg_data, 64'hBEEF);
        tick();
        chk("t3_empty", 64'(msg_valid), 64'd0);
        chk("t3_pause_low", 64'(lfsr_pause), 64'd0);
        chk("t3_ovf_end", 64'(overflow), 64'd1);

        // 5: clear mid-stream with 7 words buffered
        msg_ready = 1'b0;
        lfsr_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            lfsr_data = 64'h300 + 64'(k);
            tick();
        end
        lfsr_valid = 1'b0;
        chk("t5_count7", 64'(dut.count_q), 64'd7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_valid", 64'(msg_valid), 64'd0);
        chk("t5_count", 64'(dut.count_q), 64'd0);
        chk("t5_pause", 64'(lfsr_pause), 64'd0);
        chk("t5_ovf", 64'(overflow), 64'd0);
        chk("t5_state", 64'(dut.state_q), 64'd0);
        lfsr_data = 64'h55;
        lfsr_valid = 1'b1;
        tick();
        lfsr_valid = 1'b0;
        chk("t5_new_valid", 64'(msg_valid), 64'd1);
        chk("t5_new_data", msg_data, 64'h55);
        msg_ready = 1'b1;
        tick();
        chk("t5_new_empty", 64'(msg_valid), 64'd0);

        // 4: five words, lfsr_done, toggling ready
        msg_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        lfsr_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            lfsr_data = 64'hA0 + 64'(k);
            tick();
        end
        lfsr_valid = 1'b0;
        lfsr_done = 1'b1;
        tick();
        chk("t4_not_done", 64'(stream_done), 64'd0);
        popped = 0;
        for (int c = 0; c < 10; c++) begin
            msg_ready = (c % 2 == 0);
            if (msg_ready) begin
                chk("t4_data", msg_data, 64'hA1 + 64'(popped));
            end
            tick();
            if (msg_ready) begin
                popped++;
            end
            chk("t4_done", 64'(stream_done), (popped == 5) ? 64'd1 : 64'd0);
        end
        msg_ready = 1'b0;
`ifdef FEEDER_STATS_EN
        exp_cnt = 64'd5;
`else
        exp_cnt = 64'd0;
`endif
        chk("t4_mcnt", msg_count, exp_cnt);
        chk("t4_empty", 64'(msg_valid), 64'd0);
        chk("t4_pause", 64'(lfsr_pause), 64'd0);

        // 6: zero-length stream
        lfsr_done = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_idle", 64'(stream_done), 64'd0);
        lfsr_done = 1'b1;
        tick();
        chk("t6_done", 64'(stream_done), 64'd1);
        chk("t6_valid", 64'(msg_valid), 64'd0);
        tick();
        chk("t6_hold", 64'(stream_done), 64'd1);
        chk("t6_valid2", 64'(msg_valid), 64'd0);
        chk("t6_pause", 64'(lfsr_pause), 64'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
